// File: rtl/cpu_dmem_pkg.sv
// cpu_dmem_pkg: shared definitions for the cpu_dmem data-memory slice.
//   funct3_e      load/store width codes carried in ram_ctrl[4:2]
//   CTRL_*        bit positions inside ram_ctrl
//   MMIO_*        MMIO window base and register offsets (DMEM_MMIO_EN builds)
//   fmt_load()    lane select plus sign/zero extension of a loaded word
package cpu_dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_WR    = 1;
  localparam int unsigned CTRL_F3_LO = 2;

  localparam logic [31:0] MMIO_BASE     = 32'hFFFF_FF00;
  localparam logic [3:0]  MMIO_CNT_LO   = 4'h0;
  localparam logic [3:0]  MMIO_CNT_HI   = 4'h4;
  localparam logic [3:0]  MMIO_GPIO_OUT = 4'h8;
  localparam logic [3:0]  MMIO_GPIO_IN  = 4'hC;

  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      F3_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_dmem_if.sv
// cpu_dmem_if: core load/store port.
//   ram_ctrl  [4:2] funct3, [1] write, [0] enable   (master -> slave)
//   ram_addr  byte address                          (master -> slave)
//   ram_din   store data, low lanes used            (master -> slave)
//   ram_dout  formatted load result, latency 1      (slave -> master)
interface cpu_dmem_if;
  logic [4:0]  ram_ctrl;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  modport master (output ram_ctrl, ram_addr, ram_din, input ram_dout);
  modport slave  (input ram_ctrl, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/cpu_dmem_bram.sv
// cpu_dmem_bram: 2**DEPTH_LOG2 x 32 single-port synchronous RAM with
// per-byte write enables.
//   clk      clock
//   re_i     read enable; rdata_o updates only on a read, otherwise holds
//   we_i     byte write enables (lane i = bits [8i+7:8i])
//   addr_i   word index
//   wdata_i  write data, already lane-aligned
//   rdata_o  registered read data
module cpu_dmem_bram #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [3:0]            we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[addr_i];
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/cpu_dmem.sv
// cpu_dmem: data-memory responder on the core load/store port.
//   clk, rst      clock; synchronous active-high reset
//   bus           cpu_dmem_if.slave (ram_ctrl, ram_addr, ram_din, ram_dout)
//   err_clr       clears sticky error flags and fault_addr
//   err_misalign  sticky misaligned-access flag
//   err_range     sticky out-of-range / illegal-funct3 flag
//   fault_addr    address of first fault since reset/clear
//   gpio_in       MMIO input (DMEM_MMIO_EN only)
//   gpio_out      MMIO output register (0 without DMEM_MMIO_EN)
// Build option: define DMEM_MMIO_EN to add the 16-byte MMIO window at
// 0xFFFF_FF00 (cycle counter, gpio_out, gpio_in).
module cpu_dmem #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic             clk,
  input  logic             rst,
  cpu_dmem_if.slave        bus,
  input  logic             err_clr,
  output logic             err_misalign,
  output logic             err_range,
  output logic [31:0]      fault_addr,
  input  logic [7:0]       gpio_in,
  output logic [7:0]       gpio_out
);
  import cpu_dmem_pkg::*;

  logic [2:0]  f3;
  logic        acc_en, acc_wr;
  logic [31:0] addr, off;
  logic        is_b, is_h, is_w;
  logic        misalign, range_bad, fault, in_ram, in_mmio;
  logic [3:0]  be, bram_we;
  logic        bram_re;
  logic [31:0] bram_wdata, bram_rdata, word;

  assign f3     = bus.ram_ctrl[CTRL_F3_LO +: 3];
  assign acc_en = bus.ram_ctrl[CTRL_EN];
  assign acc_wr = bus.ram_ctrl[CTRL_WR];
  assign addr   = bus.ram_addr;
  assign off    = addr - BASE_ADDR;

`ifdef DMEM_MMIO_EN
  assign in_mmio = (addr[31:4] == MMIO_BASE[31:4]);
`else
  assign in_mmio = 1'b0;
`endif

  always_comb begin
    is_b      = (f3 == F3_B) || (f3 == F3_BU);
    is_h      = (f3 == F3_H) || (f3 == F3_HU);
    is_w      = (f3 == F3_W);
    in_ram    = (addr >= BASE_ADDR) && (off[31:DEPTH_LOG2+2] == '0);
    misalign  = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
    range_bad = !(is_b || is_h || is_w) || !(in_ram || in_mmio) || (in_mmio && !is_w);
    fault     = acc_en && (misalign || range_bad);
  end

  // Lane enables and lane-shifted store data.
  always_comb begin
    be = 4'b1111;
    if (is_b)      be = 4'b0001 << off[1:0];
    else if (is_h) be = off[1] ? 4'b1100 : 4'b0011;
    bram_wdata = bus.ram_din << {off[1:0], 3'b000};
    bram_we    = (acc_en && acc_wr && !fault && in_ram && !rst) ? be : '0;
    bram_re    = acc_en && !acc_wr && !fault && in_ram && !rst;
  end

  cpu_dmem_bram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_bram (
    .clk     (clk),
    .re_i    (bram_re),
    .we_i    (bram_we),
    .addr_i  (off[DEPTH_LOG2+1:2]),
    .wdata_i (bram_wdata),
    .rdata_o (bram_rdata)
  );

  // Sticky error flags. A clear in the same cycle as a fault is applied
  // first, so the new fault re-arms its flag and captures fault_addr.
  logic        mis_q, mis_d, rng_q, rng_d;
  logic [31:0] fa_q, fa_d;

  always_comb begin
    mis_d = mis_q;
    rng_d = rng_q;
    fa_d  = fa_q;
    if (err_clr) begin
      mis_d = 1'b0;
      rng_d = 1'b0;
      fa_d  = '0;
    end
    if (fault) begin
      if (!mis_d && !rng_d) fa_d = addr;
      if (misalign) mis_d = 1'b1;
      else          rng_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
      rng_q <= 1'b0;
      fa_q  <= '0;
    end else begin
      mis_q <= mis_d;
      rng_q <= rng_d;
      fa_q  <= fa_d;
    end
  end

  assign err_misalign = mis_q;
  assign err_range    = rng_q;
  assign fault_addr   = fa_q;

  // Pending-load state. ram_dout is formatted from these registers and the
  // RAM output, which both change only when a load is accepted, so the
  // result holds between loads. ld_zero_q forces 0 after reset or a fault.
  logic       ld_zero_q;
  logic [1:0] ld_off_q;
  logic [2:0] ld_f3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_zero_q <= 1'b1;
      ld_off_q  <= '0;
      ld_f3_q   <= '0;
    end else if (acc_en && !acc_wr) begin
      ld_zero_q <= fault;
      ld_off_q  <= addr[1:0];
      ld_f3_q   <= f3;
    end
  end

`ifdef DMEM_MMIO_EN
  logic [63:0] cnt_q;
  logic [31:0] cnt_hi_q, mmio_rd_q;
  logic [7:0]  gpio_q;
  logic        ld_mmio_q, mmio_acc;

  assign mmio_acc = acc_en && in_mmio && !fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cnt_hi_q  <= '0;
      mmio_rd_q <= '0;
      gpio_q    <= '0;
      ld_mmio_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (acc_en && !acc_wr) ld_mmio_q <= in_mmio;
      if (mmio_acc && acc_wr && (addr[3:0] == MMIO_GPIO_OUT)) gpio_q <= bus.ram_din[7:0];
      if (mmio_acc && !acc_wr) begin
        case (addr[3:0])
          MMIO_CNT_LO: begin
            mmio_rd_q <= cnt_q[31:0];
            cnt_hi_q  <= cnt_q[63:32];
          end
          MMIO_CNT_HI:   mmio_rd_q <= cnt_hi_q;
          MMIO_GPIO_OUT: mmio_rd_q <= {24'h0, gpio_q};
          MMIO_GPIO_IN:  mmio_rd_q <= {24'h0, gpio_in};
          default:       mmio_rd_q <= '0;
        endcase
      end
    end
  end

  assign word     = ld_mmio_q ? mmio_rd_q : bram_rdata;
  assign gpio_out = gpio_q;
`else
  logic unused_gpio;
  assign unused_gpio = ^gpio_in;
  assign word        = bram_rdata;
  assign gpio_out    = '0;
`endif

  assign bus.ram_dout = ld_zero_q ? '0 : fmt_load(word, ld_off_q, ld_f3_q);

endmodule

// File: tb/tb_cpu_dmem.sv
module tb_cpu_dmem;

  logic        clk = 1'b0;
  logic        rst, err_clr, err_misalign, err_range;
  logic [31:0] fault_addr;
  logic [7:0]  gpio_in, gpio_out;

  always #5 clk = ~clk;

  cpu_dmem_if bus_if ();

  cpu_dmem #(
    .DEPTH_LOG2 (12),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .err_clr      (err_clr),
    .err_misalign (err_misalign),
    .err_range    (err_range),
    .fault_addr   (fault_addr),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out)
  );

  localparam logic [4:0] IDLE = 5'b000_0_0;
  localparam logic [4:0] LB   = 5'b000_0_1;
  localparam logic [4:0] LH   = 5'b001_0_1;
  localparam logic [4:0] LW   = 5'b010_0_1;
  localparam logic [4:0] LBU  = 5'b100_0_1;
  localparam logic [4:0] LHU  = 5'b101_0_1;
  localparam logic [4:0] SB   = 5'b000_1_1;
  localparam logic [4:0] SH   = 5'b001_1_1;
  localparam logic [4:0] SW   = 5'b010_1_1;

  int unsigned n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Reference model: byte-addressed memory and architectural outputs.
  logic [7:0]  m_mem [0:16383];
  logic [31:0] m_dout;
  logic        m_mis, m_rng;
  logic [31:0] m_fa;

  task automatic model(input logic [4:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] din, input logic clr, input logic r);
    logic [2:0]  f3;
    bit          legal, win, mis, rng;
    int          size;
    logic [31:0] v;
    f3    = ctrl[4:2];
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef DMEM_MMIO_EN
    win = (addr >= 32'hFFFF_FF00) && (addr < 32'hFFFF_FF10);
`else
    win = 1'b0;
`endif
    mis = legal && ((addr % size) != 0);
    rng = !mis && (!legal || !((addr < 32'h4000) || win) || (win && size != 4));
    if (r) begin
      m_dout = '0; m_mis = 0; m_rng = 0; m_fa = '0;
      return;
    end
    if (clr) begin m_mis = 0; m_rng = 0; m_fa = '0; end
    if (!ctrl[0]) return;
    if (mis || rng) begin
      if (!m_mis && !m_rng) m_fa = addr;
      if (mis) m_mis = 1; else m_rng = 1;
      if (!ctrl[1]) m_dout = '0;
      return;
    end
    if (win) begin
      if (!ctrl[1]) m_dout = '0;
      return;
    end
    if (ctrl[1]) begin
      for (int k = 0; k < size; k++) m_mem[addr + k] = 8'(din >> (8 * k));
    end else begin
      v = '0;
      for (int k = 0; k < size; k++) v = v | (32'(m_mem[addr + k]) << (8 * k));
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      m_dout = v;
    end
  endtask

  task automatic step(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] din,
                      input logic clr = 1'b0, input logic r = 1'b0);
    bus_if.ram_ctrl = ctrl;
    bus_if.ram_addr = addr;
    bus_if.ram_din  = din;
    err_clr = clr;
    rst     = r;
    model(ctrl, addr, din, clr, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic mis, input logic rng, input logic [31:0] fa);
    check({tag, ".misalign"}, 32'(err_misalign), 32'(mis));
    check({tag, ".range"},    32'(err_range),    32'(rng));
    check({tag, ".fault_addr"}, fault_addr, fa);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] v1, v2;

    vecs = '{
      '{"sw_deadbeef", SW,   32'h10, 32'hDEAD_BEEF, 32'h0000_0000},
      '{"lb_10",       LB,   32'h10, 32'h0,         32'hFFFF_FFEF},
      '{"lbu_10",      LBU,  32'h10, 32'h0,         32'h0000_00EF},
      '{"lh_10",       LH,   32'h10, 32'h0,         32'hFFFF_BEEF},
      '{"lhu_10",      LHU,  32'h10, 32'h0,         32'h0000_BEEF},
      '{"lw_10",       LW,   32'h10, 32'h0,         32'hDEAD_BEEF},
      '{"lb_13",       LB,   32'h13, 32'h0,         32'hFFFF_FFDE},
      '{"lbu_11",      LBU,  32'h11, 32'h0,         32'h0000_00BE},
      '{"lh_12",       LH,   32'h12, 32'h0,         32'hFFFF_DEAD},
      '{"idle_hold",   IDLE, 32'h10, 32'h0,         32'hFFFF_DEAD},
      '{"sw_20",       SW,   32'h20, 32'h1122_3344, 32'hFFFF_DEAD},
      '{"sb_21",       SB,   32'h21, 32'hFFFF_FF5A, 32'hFFFF_DEAD},
      '{"lw_20_sb",    LW,   32'h20, 32'h0,         32'h1122_5A44},
      '{"sh_22",       SH,   32'h22, 32'h1234_ABCD, 32'h1122_5A44},
      '{"lw_20_sh",    LW,   32'h20, 32'h0,         32'hABCD_5A44},
      '{"lhu_22",      LHU,  32'h22, 32'h0,         32'h0000_ABCD}
    };

    gpio_in = 8'h3C;
    err_clr = 1'b0;
    m_dout = '0; m_mis = 0; m_rng = 0; m_fa = '0;

    // Reset state
    step(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    step(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    check("rst.dout", bus_if.ram_dout, 32'h0);
    check_flags("rst", 0, 0, 32'h0);
    check("rst.gpio_out", 32'(gpio_out), 32'h0);

    // Table-driven basic loads/stores
    foreach (vecs[i]) begin
      step(vecs[i].ctrl, vecs[i].addr, vecs[i].din);
      check(vecs[i].name, bus_if.ram_dout, vecs[i].exp_dout);
    end

    // Misalignment: flag set, first address kept, memory untouched
    step(SH, 32'h23, 32'h0000_FFFF);
    check_flags("sh_23", 1, 0, 32'h23);
    step(LW, 32'h06, 32'h0);
    check("lw_06.dout", bus_if.ram_dout, 32'h0);
    check_flags("lw_06", 1, 0, 32'h23);
    step(LW, 32'h20, 32'h0);
    check("mem_unchanged", bus_if.ram_dout, 32'hABCD_5A44);
    step(IDLE, 32'h0, 32'h0, 1'b1);
    check_flags("clr1", 0, 0, 32'h0);

    // Range / illegal funct3
    step(LW, 32'h4000, 32'h0);
    check("lw_4000.dout", bus_if.ram_dout, 32'h0);
    check_flags("lw_4000", 0, 1, 32'h4000);
    step(5'b111_0_1, 32'h0, 32'h0);
    check_flags("f3_111", 0, 1, 32'h4000);
    step(IDLE, 32'h0, 32'h0, 1'b1);
    step(SW, 32'h3FFC, 32'hCAFE_F00D);
    step(LW, 32'h3FFC, 32'h0);
    check("lw_3ffc", bus_if.ram_dout, 32'hCAFE_F00D);
    check_flags("lw_3ffc", 0, 0, 32'h0);
    step(LH, 32'h4001, 32'h0);
    check_flags("mis_wins", 1, 0, 32'h4001);
    step(LW, 32'h2, 32'h0, 1'b1);
    check_flags("clr_fault_same", 1, 0, 32'h2);
    step(5'b110_1_1, 32'h8, 32'h0, 1'b1);
    check_flags("clr_f3_110", 0, 1, 32'h8);
    step(IDLE, 32'h0, 32'h0, 1'b1);

    // Reset overrides a simultaneous store
    step(SW, 32'h30, 32'h77);
    step(LW, 32'h30, 32'h0);
    step(LW, 32'h4000, 32'h0);
    step(SW, 32'h30, 32'h1, 1'b0, 1'b1);
    check("rst_sw.dout", bus_if.ram_dout, 32'h0);
    check_flags("rst_sw", 0, 0, 32'h0);
    step(LW, 32'h30, 32'h0);
    check("rst_sw.mem", bus_if.ram_dout, 32'h77);

    // Randomized traffic against the model
    for (int a = 0; a < 64; a += 4) step(SW, 32'(a), $urandom);
    step(SW, 32'h3FFC, $urandom);
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  c;
      logic [31:0] ad;
      logic [2:0]  f;
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r % 5)
        0: f = 3'd0;
        1: f = 3'd1;
        2: f = 3'd2;
        3: f = 3'd4;
        default: f = 3'd5;
      endcase
      if (r >= 8) f = 3'($urandom_range(0, 7));
      c = {f, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) != 0)};
      r = $urandom_range(0, 9);
      if (r < 8)       ad = 32'($urandom_range(0, 63));
      else if (r == 8) ad = 32'h3FFC + 32'($urandom_range(0, 3));
      else             ad = 32'h4000 + 32'($urandom_range(0, 32'hFFFF));
      step(c, ad, $urandom, 1'($urandom_range(0, 15) == 0));
      check("rand.dout", bus_if.ram_dout, m_dout);
      check_flags("rand", m_mis, m_rng, m_fa);
    end
    step(IDLE, 32'h0, 32'h0, 1'b1);

`ifdef DMEM_MMIO_EN
    step(SW, 32'hFFFF_FF08, 32'h0000_12A5);
    check("mmio.gpio_out", 32'(gpio_out), 32'hA5);
    step(LW, 32'hFFFF_FF08, 32'h0);
    check("mmio.rd_gpio_out", bus_if.ram_dout, 32'hA5);
    step(LW, 32'hFFFF_FF0C, 32'h0);
    check("mmio.rd_gpio_in", bus_if.ram_dout, 32'h3C);
    step(LW, 32'hFFFF_FF00, 32'h0);
    v1 = bus_if.ram_dout;
    for (int k = 0; k < 4; k++) step(IDLE, 32'h0, 32'h0);
    step(LW, 32'hFFFF_FF00, 32'h0);
    v2 = bus_if.ram_dout;
    check("mmio.cnt_delta", v2 - v1, 32'd5);
    step(LH, 32'hFFFF_FF00, 32'h0);
    check_flags("mmio.lh", 0, 1, 32'hFFFF_FF00);
    step(IDLE, 32'h0, 32'h0, 1'b1);
`else
    v1 = '0;
    v2 = '0;
    step(SW, 32'hFFFF_FF08, 32'h0000_00A5);
    check("nommio.gpio_out", 32'(gpio_out), 32'h0);
    check_flags("nommio.sw", v1[0], 1, 32'hFFFF_FF08 | v2);
    step(IDLE, 32'h0, 32'h0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
